vga_text_ctrl: RTL and testbench
================================

Name: vga_text_ctrl

Overview:
Text-mode VGA front end that drives the character renderer. It generates 640x480@60 timing and walks a 70x30 grid of 9x16 character cells. For each pixel it fetches the character code from a synchronous text RAM and presents char, font row/column, valid, cursor and blink signals, with hsync/vsync pre-delayed to line up with the renderer's registered pixel output.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_VIS, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
CELL_W, 9, pixels per character column
CELL_H, 16, lines per character row
COLS, 70, character columns
ROWS, 30, character rows
BLINK_DIV, 12500000, pclk cycles per clk_1s half-period

Ports:
pclk  input  1  pixel clock, 25 MHz; sole clock
rst  input  1  synchronous, active-high reset
vram_addr  output  12  text RAM read address, row*COLS+col
vram_data  input  8  text RAM data; valid 1 cycle after vram_addr
cursor_en  input  1  cursor display enable
cur_col  input  7  cursor column
cur_row  input  5  cursor row
char  output  8  character code for current pixel
h_font  output  4  pixel column within cell, 0..CELL_W-1
v_font  output  4  pixel row within cell, 0..CELL_H-1
c_valid  output  1  pixel lies inside the character grid
cursor  output  1  current cell is the cursor cell and cursor_en=1
h_cur  output  7  current cell column
v_cur  output  5  current cell row
clk_1s  output  1  blink square wave, period 2*BLINK_DIV cycles
hsync  output  1  active-low horizontal sync
vsync  output  1  active-low vertical sync
frame_start  output  1  one-cycle pulse aligned with pixel (0,0) on the char-side outputs

Behaviour:
- Stage 0 counters:
  - h_cnt runs 0..H_TOTAL-1 (H_TOTAL=800). At wrap, v_cnt advances 0..V_TOTAL-1 (V_TOTAL=525).
  - Cell counters are incremental; no dividers or multipliers.
  - hf counts 0..CELL_W-1. On its wrap, col++.
  - hf, col reset to 0 when h_cnt wraps.
  - vf counts 0..CELL_H-1 and advances on h_cnt wrap. On vf wrap, row++ and row_base += COLS.
  - vf, row, row_base reset to 0 when v_cnt wraps.
- Stage 1:
  - vram_addr <= row_base + col, registered.
  - Stage-0 hf, vf, col, row and in_grid are registered alongside.
  - in_grid = (h_cnt < COLS*CELL_W) && (v_cnt < ROWS*CELL_H), i.e. h<630 and v<480.
- Stage 2, all char-side outputs registered:
  - char <= vram_data.
  - h_font, v_font, h_cur, v_cur, c_valid <= stage-1 copies.
  - cursor <= cursor_en & c_valid_s1 & (col_s1==cur_col) & (row_s1==cur_row).
- Latency:
  - Char-side outputs lag counter position by 2 cycles.
  - hsync/vsync lag by 3 cycles, matching the renderer's output register.
- Sync decode on stage-0 counters:
  - hsync low for 656<=h_cnt<752.
  - vsync low for 490<=v_cnt<492.
- Grid boundaries:
  - Pixels 630..639 and all blanking → c_valid=0.
  - h_font/v_font/h_cur/v_cur hold don't-care counter values there but must not exceed field widths.
  - vram_addr stays ≤ 2099 while in_grid.
- frame_start = 1 for exactly one cycle, when char-side outputs correspond to h=0,v=0.
- Blink:
  - Blink counter 0..BLINK_DIV-1 runs freely, independent of video timing.
  - On terminal count it resets to 0 and clk_1s toggles.
- Reset, synchronous and dominant over all counting, effective next edge:
  - All counters 0.
  - vram_addr=0, char=0, h_font=0, v_font=0, h_cur=0, v_cur=0.
  - c_valid=0, cursor=0, frame_start=0, clk_1s=0.
  - hsync=1, vsync=1.
  - Pipeline registers cleared.
- Reset mid-frame: timing restarts at (0,0). First frame_start occurs 2 cycles after rst deasserts. No partial sync pulse is extended.
- cursor_en, cur_col and cur_row are sampled every cycle and may change at any time. cur_col>=COLS or cur_row>=ROWS means no cell ever asserts cursor.

Test Plan:
- Reset: hold rst 5 cycles mid-line → next cycle all outputs at reset values; after release, frame_start pulses at cycle 2 with h_font=0, v_font=0, h_cur=0.
- Sync timing: run one frame → hsync low 96 cycles, period 800; vsync low 1600 cycles (2 lines), period 420000; hsync falls 659 cycles after frame_start-2 reference.
- Addressing: line 0 → vram_addr 0 for h 0..8, 1 for h 9..17, 69 at h 621; line 16 → addr 70 at h 0; line 479 → addr 2099 at h 621. Return vram_data=addr[7:0] → char matches 2 cycles later.
- Grid edge: h 630..639 and v≥480 → c_valid=0; h=629 → c_valid=1, h_font=8, h_cur=69.
- Cursor: cursor_en=1, cur_col=3, cur_row=2 → cursor=1 exactly for h 27..35 on lines 32..47 (144 cycles per frame); cursor_en=0 → never; cur_col=100 → never.
- Blink: BLINK_DIV=4 → clk_1s toggles every 4 cycles from reset (first rise at cycle 4); rst mid-count returns clk_1s to 0.

Source files
------------

// File: rtl/vga_text_ctrl.sv
// Text-mode VGA front end: 640x480@60 raster, 70x30 grid of 9x16 cells.
// A three-stage pipeline feeds the character renderer:
//   stage 0  raster counters and incremental cell counters
//   stage 1  text RAM address plus registered cell position
//   stage 2  character code and font coordinates, aligned with the RAM data
// hsync/vsync pass through one extra register so they line up with the
// renderer's own registered pixel output.
module vga_text_ctrl #(
  parameter int H_VIS     = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VIS     = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CELL_W    = 9,
  parameter int CELL_H    = 16,
  parameter int COLS      = 70,
  parameter int ROWS      = 30,
  parameter int BLINK_DIV = 12500000
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [11:0] vram_addr,
  input  logic [7:0]  vram_data,
  input  logic        cursor_en,
  input  logic [6:0]  cur_col,
  input  logic [4:0]  cur_row,
  output logic [7:0]  char,
  output logic [3:0]  h_font,
  output logic [3:0]  v_font,
  output logic        c_valid,
  output logic        cursor,
  output logic [6:0]  h_cur,
  output logic [4:0]  v_cur,
  output logic        clk_1s,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HCW      = $clog2(H_TOTAL);
  localparam int VCW      = $clog2(V_TOTAL);
  localparam int GRID_W   = COLS * CELL_W;
  localparam int GRID_H   = ROWS * CELL_H;
  localparam int HS_START = H_VIS + H_FP;
  localparam int HS_END   = H_VIS + H_FP + H_SYNC;
  localparam int VS_START = V_VIS + V_FP;
  localparam int VS_END   = V_VIS + V_FP + V_SYNC;
  localparam int BCW      = ($clog2(BLINK_DIV) < 1) ? 1 : $clog2(BLINK_DIV);

  // Stage 0 state
  logic [HCW-1:0] r_h_cnt;
  logic [VCW-1:0] r_v_cnt;
  logic [3:0]     r_hf;
  logic [6:0]     r_col;
  logic [3:0]     r_vf;
  logic [4:0]     r_row;
  logic [11:0]    r_row_base;

  // Stage 1 state
  logic [11:0]    r_vram_addr;
  logic [3:0]     r_hf_s1;
  logic [3:0]     r_vf_s1;
  logic [6:0]     r_col_s1;
  logic [4:0]     r_row_s1;
  logic           r_valid_s1;
  logic           r_fs_s1;

  // Stage 2 state (char-side outputs)
  logic [7:0]     r_char;
  logic [3:0]     r_h_font;
  logic [3:0]     r_v_font;
  logic [6:0]     r_h_cur;
  logic [4:0]     r_v_cur;
  logic           r_c_valid;
  logic           r_cursor;
  logic           r_frame_start;

  // Sync delay line, three registers deep
  logic           r_hs_s1, r_hs_s2, r_hs_s3;
  logic           r_vs_s1, r_vs_s2, r_vs_s3;

  // Blink divider
  logic [BCW-1:0] r_blink_cnt;
  logic           r_clk_1s;

  // Stage 0 decodes
  logic w_h_end, w_v_end, w_hf_end, w_vf_end;
  logic w_in_grid, w_hs_n, w_vs_n, w_origin, w_blink_end;

  // Wrap detection, grid membership and sync decode on the raw counters
  always_comb begin
    w_h_end     = (r_h_cnt == HCW'(H_TOTAL - 1));
    w_v_end     = (r_v_cnt == VCW'(V_TOTAL - 1));
    w_hf_end    = (r_hf == 4'(CELL_W - 1));
    w_vf_end    = (r_vf == 4'(CELL_H - 1));
    w_in_grid   = (r_h_cnt < HCW'(GRID_W)) && (r_v_cnt < VCW'(GRID_H));
    w_hs_n      = !((r_h_cnt >= HCW'(HS_START)) && (r_h_cnt < HCW'(HS_END)));
    w_vs_n      = !((r_v_cnt >= VCW'(VS_START)) && (r_v_cnt < VCW'(VS_END)));
    w_origin    = (r_h_cnt == '0) && (r_v_cnt == '0);
    w_blink_end = (r_blink_cnt == BCW'(BLINK_DIV - 1));
  end

  // Stage 0: raster position and incremental cell counters (no dividers)
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
      r_hf       <= '0;
      r_col      <= '0;
      r_vf       <= '0;
      r_row      <= '0;
      r_row_base <= '0;
    end else if (w_h_end) begin
      r_h_cnt <= '0;
      r_hf    <= '0;
      r_col   <= '0;
      if (w_v_end) begin
        r_v_cnt    <= '0;
        r_vf       <= '0;
        r_row      <= '0;
        r_row_base <= '0;
      end else begin
        r_v_cnt <= r_v_cnt + 1'b1;
        if (w_vf_end) begin
          r_vf       <= '0;
          r_row      <= r_row + 1'b1;
          r_row_base <= r_row_base + 12'(COLS);
        end else begin
          r_vf <= r_vf + 1'b1;
        end
      end
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
      if (w_hf_end) begin
        r_hf  <= '0;
        r_col <= r_col + 1'b1;
      end else begin
        r_hf <= r_hf + 1'b1;
      end
    end
  end

  // Stage 1: issue the text RAM read and carry the cell position with it
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vram_addr <= '0;
      r_hf_s1     <= '0;
      r_vf_s1     <= '0;
      r_col_s1    <= '0;
      r_row_s1    <= '0;
      r_valid_s1  <= 1'b0;
      r_fs_s1     <= 1'b0;
    end else begin
      r_vram_addr <= r_row_base + {5'b0, r_col};
      r_hf_s1     <= r_hf;
      r_vf_s1     <= r_vf;
      r_col_s1    <= r_col;
      r_row_s1    <= r_row;
      r_valid_s1  <= w_in_grid;
      r_fs_s1     <= w_origin;
    end
  end

  // Stage 2: capture RAM data alongside the matching cell position
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_char        <= '0;
      r_h_font      <= '0;
      r_v_font      <= '0;
      r_h_cur       <= '0;
      r_v_cur       <= '0;
      r_c_valid     <= 1'b0;
      r_cursor      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_char        <= vram_data;
      r_h_font      <= r_hf_s1;
      r_v_font      <= r_vf_s1;
      r_h_cur       <= r_col_s1;
      r_v_cur       <= r_row_s1;
      r_c_valid     <= r_valid_s1;
      // Out-of-range cursor coordinates never match a valid cell.
      r_cursor      <= cursor_en & r_valid_s1 & (r_col_s1 == cur_col) & (r_row_s1 == cur_row);
      r_frame_start <= r_fs_s1;
    end
  end

  // Sync delay line: one register beyond the char side for the renderer
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_hs_s1 <= 1'b1;
      r_hs_s2 <= 1'b1;
      r_hs_s3 <= 1'b1;
      r_vs_s1 <= 1'b1;
      r_vs_s2 <= 1'b1;
      r_vs_s3 <= 1'b1;
    end else begin
      r_hs_s1 <= w_hs_n;
      r_hs_s2 <= r_hs_s1;
      r_hs_s3 <= r_hs_s2;
      r_vs_s1 <= w_vs_n;
      r_vs_s2 <= r_vs_s1;
      r_vs_s3 <= r_vs_s2;
    end
  end

  // Free-running blink divider, unrelated to the raster
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_clk_1s    <= 1'b0;
    end else if (w_blink_end) begin
      r_blink_cnt <= '0;
      r_clk_1s    <= ~r_clk_1s;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign vram_addr   = r_vram_addr;
  assign char        = r_char;
  assign h_font      = r_h_font;
  assign v_font      = r_v_font;
  assign h_cur       = r_h_cur;
  assign v_cur       = r_v_cur;
  assign c_valid     = r_c_valid;
  assign cursor      = r_cursor;
  assign frame_start = r_frame_start;
  assign hsync       = r_hs_s3;
  assign vsync       = r_vs_s3;
  assign clk_1s      = r_clk_1s;

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Bench for vga_text_ctrl on a shrunken raster (56x40 total, 36x32 grid of
// 9x16 cells, 4x2 cells) so several whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_text_ctrl;

  localparam int H_VIS = 40, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_VIS = 34, V_FP = 2, V_SYNC = 2, V_BP = 2;
  localparam int CELL_W = 9, CELL_H = 16, COLS = 4, ROWS = 2;
  localparam int BLINK_DIV = 4;
  localparam int H_TOT = 56, V_TOT = 40, FRAME = H_TOT * V_TOT;

  // ---------------- clock / reset ----------------
  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic        cursor_en = 1'b0;
  logic [6:0]  cur_col = '0;
  logic [4:0]  cur_row = '0;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;
  logic [7:0]  char;
  logic [3:0]  h_font, v_font;
  logic        c_valid, cursor, clk_1s, hsync, vsync, frame_start;
  logic [6:0]  h_cur;
  logic [4:0]  v_cur;

  always #20 pclk = ~pclk;

  vga_text_ctrl #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CELL_W(CELL_W), .CELL_H(CELL_H), .COLS(COLS), .ROWS(ROWS),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .pclk(pclk), .rst(rst), .vram_addr(vram_addr), .vram_data(vram_data),
    .cursor_en(cursor_en), .cur_col(cur_col), .cur_row(cur_row),
    .char(char), .h_font(h_font), .v_font(v_font), .c_valid(c_valid),
    .cursor(cursor), .h_cur(h_cur), .v_cur(v_cur), .clk_1s(clk_1s),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  // Text RAM stand-in: contents are a fixed function of the address.
  function automatic logic [7:0] ram_val(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction
  assign vram_data = ram_val(int'(vram_addr));

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: edges since reset release, and inputs seen at the last edge.
  int         cyc = 0;
  logic       in_rst = 1'b0;
  logic       started = 1'b0;
  logic       l_en = 1'b0;
  logic [6:0] l_col = '0;
  logic [4:0] l_row = '0;

  always @(posedge pclk) begin
    in_rst  <= rst;
    started <= started | rst;
    cyc     <= rst ? 0 : cyc + 1;
    l_en    <= cursor_en;
    l_col   <= cur_col;
    l_row   <= cur_row;
  end

  // Per-cycle comparison against a position-based model of the raster.
  always @(negedge pclk) begin : compare
    int p, h, v, col, row;
    logic grid;
    if (started) begin
      if (in_rst) begin
        check("rst_vram_addr", 32'(vram_addr), 32'd0);
        check("rst_char", 32'(char), 32'd0);
        check("rst_h_font", 32'(h_font), 32'd0);
        check("rst_v_font", 32'(v_font), 32'd0);
        check("rst_h_cur", 32'(h_cur), 32'd0);
        check("rst_v_cur", 32'(v_cur), 32'd0);
        check("rst_c_valid", 32'(c_valid), 32'd0);
        check("rst_cursor", 32'(cursor), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_clk_1s", 32'(clk_1s), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
      end else begin
        check("clk_1s", 32'(clk_1s), 32'((cyc / BLINK_DIV) % 2));
        if (cyc >= 1) begin
          p = cyc - 1;
          h = p % H_TOT;
          v = (p / H_TOT) % V_TOT;
          if (h < COLS * CELL_W && v < ROWS * CELL_H)
            check("vram_addr", 32'(vram_addr), 32'((v / CELL_H) * COLS + h / CELL_W));
        end
        if (cyc >= 2) begin
          p = cyc - 2;
          h = p % H_TOT;
          v = (p / H_TOT) % V_TOT;
          col = h / CELL_W;
          row = v / CELL_H;
          grid = (h < COLS * CELL_W) && (v < ROWS * CELL_H);
          check("c_valid", 32'(c_valid), 32'(grid));
          check("frame_start", 32'(frame_start), 32'(h == 0 && v == 0));
          check("cursor", 32'(cursor),
                32'(l_en && grid && int'(l_col) == col && int'(l_row) == row));
          if (grid) begin
            check("char", 32'(char), 32'(ram_val(row * COLS + col)));
            check("h_font", 32'(h_font), 32'(h % CELL_W));
            check("v_font", 32'(v_font), 32'(v % CELL_H));
            check("h_cur", 32'(h_cur), 32'(col));
            check("v_cur", 32'(v_cur), 32'(row));
          end
        end
        if (cyc >= 3) begin
          p = cyc - 3;
          h = p % H_TOT;
          v = (p / H_TOT) % V_TOT;
          check("hsync", 32'(hsync), 32'(!(h >= 44 && h < 52)));
          check("vsync", 32'(vsync), 32'(!(v >= 36 && v < 38)));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
  endtask

  // Wait until the model says k edges have passed since release.
  task automatic at_cyc(input int k);
    for (int i = 0; i < 50; i++) begin
      @(negedge pclk);
      if (!in_rst && cyc == k) return;
    end
    check("at_cyc_timeout", 32'd0, 32'd1);
  endtask

  // Wait until the char-side outputs correspond to raster position (h,v).
  task automatic wait_pos(input int h, input int v);
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge pclk);
      if (!in_rst && cyc >= 2 && ((cyc - 2) % H_TOT) == h &&
          (((cyc - 2) / H_TOT) % V_TOT) == v) return;
    end
    check("wait_pos_timeout", 32'd0, 32'd1);
  endtask

  task automatic post_reset_checks();
    at_cyc(1);
    check("fs_at_cyc1", 32'(frame_start), 32'd0);
    at_cyc(2);
    check("fs_at_cyc2", 32'(frame_start), 32'd1);
    check("h_font_at_cyc2", 32'(h_font), 32'd0);
    check("v_font_at_cyc2", 32'(v_font), 32'd0);
    check("h_cur_at_cyc2", 32'(h_cur), 32'd0);
    at_cyc(3);
    check("blink_at_cyc3", 32'(clk_1s), 32'd0);
    at_cyc(4);
    check("blink_at_cyc4", 32'(clk_1s), 32'd1);
  endtask

  // Count one whole frame starting at a frame_start pulse.
  task automatic count_frame(input string tag, input int exp_cursor);
    int n_cur, n_hs, n_vs, n_fs, hs_fall;
    logic prev_hs;
    bit found;
    n_cur = 0; n_hs = 0; n_vs = 0; n_fs = 0; hs_fall = -1; prev_hs = 1'b1;
    found = 0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      @(negedge pclk);
      if (frame_start === 1'b1) found = 1;
    end
    if (!found) begin
      check({tag, "_fs_timeout"}, 32'd0, 32'd1);
      return;
    end
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge pclk);
      if (cursor === 1'b1) n_cur++;
      if (hsync === 1'b0) n_hs++;
      if (vsync === 1'b0) n_vs++;
      if (frame_start === 1'b1) n_fs++;
      if (hsync === 1'b0 && prev_hs === 1'b1 && hs_fall < 0) hs_fall = i;
      prev_hs = hsync;
    end
    check({tag, "_cursor_cycles"}, 32'(n_cur), 32'(exp_cursor));
    check({tag, "_hsync_low"}, 32'(n_hs), 32'd320);
    check({tag, "_vsync_low"}, 32'(n_vs), 32'd112);
    check({tag, "_fs_pulses"}, 32'(n_fs), 32'd1);
    check({tag, "_hsync_fall"}, 32'(hs_fall), 32'd45);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick(5);
    rst = 1'b0;
    post_reset_checks();

    // Cursor on cell (2,1): h 18..26, lines 16..31.
    cursor_en = 1'b1; cur_col = 7'd2; cur_row = 5'd1;
    count_frame("cur_on", 144);

    // Grid and addressing landmarks.
    wait_pos(8, 0);
    check("addr_h9_v0", 32'(vram_addr), 32'd1);
    wait_pos(35, 0);
    check("valid_h35", 32'(c_valid), 32'd1);
    check("h_font_h35", 32'(h_font), 32'd8);
    check("h_cur_h35", 32'(h_cur), 32'd3);
    wait_pos(36, 0);
    check("valid_h36", 32'(c_valid), 32'd0);
    wait_pos(0, 16);
    check("char_row1", 32'(char), 32'(8'h04 ^ 8'h5A));
    check("v_cur_row1", 32'(v_cur), 32'd1);
    check("v_font_v16", 32'(v_font), 32'd0);
    wait_pos(34, 31);
    check("addr_last", 32'(vram_addr), 32'd7);
    wait_pos(35, 31);
    check("char_last", 32'(char), 32'(8'h07 ^ 8'h5A));
    check("v_font_v31", 32'(v_font), 32'd15);
    wait_pos(0, 32);
    check("valid_v32", 32'(c_valid), 32'd0);

    cursor_en = 1'b0;
    count_frame("cur_off", 0);
    cursor_en = 1'b1; cur_col = 7'd4; cur_row = 5'd0;
    count_frame("cur_col_eq_cols", 0);
    cur_col = 7'd100;
    count_frame("cur_col_100", 0);
    cur_col = 7'd0; cur_row = 5'd2;
    count_frame("cur_row_eq_rows", 0);

    // Cursor inputs changing at arbitrary times.
    for (int i = 0; i < 400; i++) begin
      cursor_en = 1'($urandom_range(0, 1));
      cur_col   = 7'($urandom_range(0, 5));
      cur_row   = 5'($urandom_range(0, 2));
      tick($urandom_range(1, 12));
    end

    // Mid-frame reset, then a clean frame afterwards.
    cursor_en = 1'b1; cur_col = 7'd1; cur_row = 5'd0;
    tick($urandom_range(300, 1500));
    apply_reset(5);
    post_reset_checks();
    count_frame("after_rst", 144);

    // Reset landing inside the hsync pulse.
    wait_pos(44, 3);
    apply_reset(5);
    post_reset_checks();
    tick(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
